// File: rtl/nibble_seq_pkg.sv
// Shared definitions for the nibble-serial sequencer and the external 4-bit ALU stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nibble_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIBBLE_W = 4;

    // Operation codes understood by the ALU stage; the sequencer only forwards them.
    localparam logic [1:0] ALU_SEL_AND = 2'b00;
    localparam logic [1:0] ALU_SEL_OR  = 2'b01;
    localparam logic [1:0] ALU_SEL_ADD = 2'b10;
    localparam logic [1:0] ALU_SEL_XOR = 2'b11;

endpackage

// File: rtl/nibble_serial_alu_seq.sv
// Streams WIDTH-bit operands one nibble per cycle through an external 4-bit ALU, chaining carry.
// Latency: NIBBLES+1 cycles from accepted start to the done pulse (5 for WIDTH=16).
// Backpressure: start is ignored while busy; no queueing, result is held until the next completion.
module nibble_serial_alu_seq
    import nibble_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [1:0]       op_sel,
    input  logic             op_cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [1:0]       alu_sel,
    output logic             alu_cin,
    input  logic [3:0]       alu_result,
    input  logic             alu_cout
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             carry_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [1:0]       sel_reg;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] merged;

    // Shadow with the current ALU nibble dropped into place; on the last nibble this is the full result.
    always_comb begin
        merged = shadow;
        merged[NIBBLE_W*idx +: NIBBLE_W] = alu_result;
    end

    // ALU drive: current operand nibbles and chained carry during RUN, quiet otherwise.
    assign busy    = (state == RUN);
    assign done    = (state == DONE);
    assign alu_a   = busy ? a_reg[NIBBLE_W*idx +: NIBBLE_W] : 4'd0;
    assign alu_b   = busy ? b_reg[NIBBLE_W*idx +: NIBBLE_W] : 4'd0;
    assign alu_cin = busy & carry_reg;
    assign alu_sel = sel_reg;

    // Sequencer FSM: accept in IDLE/DONE, walk nibbles in RUN, commit result atomically on the last one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sel_reg   <= 2'b00;
            shadow    <= '0;
            result    <= '0;
            cout      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_reg     <= op_a;
                        b_reg     <= op_b;
                        sel_reg   <= op_sel;
                        carry_reg <= op_cin;
                        idx       <= '0;
                        state     <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    shadow    <= merged;
                    carry_reg <= alu_cout;
                    if (idx == LAST_IDX) begin
                        result <= merged;
                        cout   <= alu_cout;
                        idx    <= '0;
                        state  <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/nibble_serial_alu_seq.md
# nibble_serial_alu_seq

Sequencer that performs WIDTH-bit operations by streaming operands one nibble per cycle through the team's external 4-bit ALU stage. It is both upstream of that stage (driving its a/b/sel/cin) and downstream of it (collecting its result/cout). The carry is chained between nibbles in a register. Operands are accepted with a start pulse; the completed WIDTH-bit result and final carry are presented with a one-cycle done pulse.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4, minimum 4
- NIBBLES, WIDTH/4, derived; not overridable
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; accepted only when busy=0
- op_a  in  WIDTH  operand A, sampled on accepted start
- op_b  in  WIDTH  operand B, sampled on accepted start
- op_sel  in  2  ALU operation, sampled on accepted start, held for whole operation
- op_cin  in  1  carry into nibble 0, sampled on accepted start
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse when result/cout become valid
- result  out  WIDTH  completed result; holds until next completion
- cout  out  1  carry out of top nibble; holds until next completion
- alu_a, alu_b  out  4  current nibble of latched A/B to the ALU
- alu_sel  out  2  latched op_sel
- alu_cin  out  1  chained carry register
- alu_result  in  4  ALU nibble result (combinational from alu_* outputs)
- alu_cout  in  1  ALU carry out

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 → latch op_a, op_b, op_sel; carry_reg<=op_cin; idx<=0; go RUN.
- RUN, each cycle: drive alu_a=A[4*idx+:4], alu_b=B[4*idx+:4], alu_sel=sel_reg, alu_cin=carry_reg. On the clock edge: shadow[4*idx+:4]<=alu_result; carry_reg<=alu_cout; idx<=idx+1.
- RUN, idx=NIBBLES-1: on the edge, result<={alu_result, shadow[lower bits]}, cout<=alu_cout; go DONE.
- DONE: done=1 for exactly this cycle; busy=0. start=1 here is accepted exactly as in IDLE (go RUN). Otherwise go IDLE.
- start while busy=1 is ignored; no queueing.
- Outside RUN: alu_a=alu_b=0, alu_cin=0, alu_sel=sel_reg.
- The carry is chained regardless of op_sel. The ALU defines cout meaning for non-arithmetic ops; the sequencer only transports it.
- idx width is clog2(NIBBLES), minimum 1 bit. idx never exceeds NIBBLES-1.

## Timing
- Reset values: state=IDLE, busy=0, done=0, result=0, cout=0, alu_a=0, alu_b=0, alu_sel=0, alu_cin=0, idx=0, carry_reg=0.
- Start accepted at edge T: RUN occupies cycles T+1 … T+NIBBLES. done=1 and result/cout valid in cycle T+NIBBLES+1. Latency is NIBBLES+1 cycles; 5 for WIDTH=16.
- busy is high exactly in RUN cycles (combinational from state).
- Back-to-back: start in the DONE cycle gives a throughput of one op per NIBBLES+1 cycles.
- result/cout change only at the completion edge; they are never partially updated.
- rst mid-operation aborts the operation. No done is produced, and all outputs return to reset values at the next edge.
- rst and start in the same cycle: rst wins; start is dropped.

## Structure
- Shared package nibble_seq_pkg:
  - state enum {IDLE, RUN, DONE}
  - NIBBLE_W=4
  - ALU op_sel constants shared with the ALU stage
- Single module. No sub-module. The ALU is external and connected at the parent level, so it can be swapped or shared.

## Test plan
The bench connects a behavioural ALU model: sel 2'b10 = add, result=a+b+cin, cout=carry. Default WIDTH=16.
- Basic add: start with A=0x1234, B=0x0FFF, sel=2'b10, cin=0 → done in cycle T+5, result=0x2233, cout=0; busy high for exactly 4 cycles; alu_a sequence 4,3,2,1.
- Carry ripple across nibbles: A=0xFFFF, B=0x0001, cin=0 → result=0x0000, cout=1; alu_cin sequence 0,1,1,1.
- Initial carry: A=0x00FF, B=0x0000, cin=1 → result=0x0100, cout=0.
- Start ignored while busy: second start with A=0x1111 asserted in RUN cycle 2 → first result unaffected, no second done.
- Back-to-back: new start (0x0001+0x0001) in the DONE cycle → second done exactly 5 cycles later, result=0x0002; first result held in between.
- Reset mid-operation: rst in RUN cycle 3 → no done; busy=0 and result=0 next cycle; a subsequent op completes correctly.
